// File: rtl/pwm_timer.sv
// -----------------------------------------------------------------------------
// pwm_timer
//   Timing core for one PWM channel. Software writes the pending on-time,
//   period and control (enable + prescale) registers. The downstream PWM state
//   machine copies them into the active counters with reload_times_i, then
//   steps the counters down with dec_t_on_i / dec_t_period_i. Each step only
//   takes effect on a prescaler tick.
//
// Ports
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   wr_en_i          register write strobe
//   wr_addr_i        0 = period, 1 = on-time, 2 = control, 3 = no register
//   wr_data_i        write data (control: bit 0 enable, bits PW+7:8 prescale)
//   dec_t_on_i       request to decrement the on-time counter
//   dec_t_period_i   request to decrement the period counter
//   reload_times_i   load the active counters from the pending registers
//   t_on_zero_o      active on-time counter is zero
//   t_period_zero_o  active period counter is zero
//   pwm_enable_o     pending enable bit (not shadowed)
//   period_done_o    one-cycle pulse after the period counter steps 1 -> 0
// -----------------------------------------------------------------------------
module pwm_timer #(
    parameter int PWM_UNIT       = 0,
    parameter int COUNT_WIDTH    = 32,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   wr_en_i,
    input  logic [1:0]             wr_addr_i,
    input  logic [COUNT_WIDTH-1:0] wr_data_i,
    input  logic                   dec_t_on_i,
    input  logic                   dec_t_period_i,
    input  logic                   reload_times_i,
    output logic                   t_on_zero_o,
    output logic                   t_period_zero_o,
    output logic                   pwm_enable_o,
    output logic                   period_done_o
);

    // Channel index is informational only.
    localparam int unused_pwm_unit = PWM_UNIT;

    // Pending (software-visible) registers
    logic [COUNT_WIDTH-1:0]    t_period_p_q, t_period_p_d;
    logic [COUNT_WIDTH-1:0]    t_on_p_q, t_on_p_d;
    logic                      enable_p_q, enable_p_d;
    logic [PRESCALE_WIDTH-1:0] prescale_p_q, prescale_p_d;

    // Active counters
    logic [COUNT_WIDTH-1:0]    on_cnt_q, on_cnt_d;
    logic [COUNT_WIDTH-1:0]    per_cnt_q, per_cnt_d;
    logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic                      period_done_q, period_done_d;

    logic                      tick;
    logic [COUNT_WIDTH-1:0]    on_load;

    assign tick = (pre_cnt_q == '0);

    // An on-time longer than the period is clamped so the output is simply 100% duty.
    assign on_load = (t_on_p_q < t_period_p_q) ? t_on_p_q : t_period_p_q;

    // Pending register writes
    always_comb begin
        t_period_p_d = t_period_p_q;
        t_on_p_d     = t_on_p_q;
        enable_p_d   = enable_p_q;
        prescale_p_d = prescale_p_q;
        if (wr_en_i) begin
            case (wr_addr_i)
                2'd0: t_period_p_d = wr_data_i;
                2'd1: t_on_p_d     = wr_data_i;
                2'd2: begin
                    enable_p_d   = wr_data_i[0];
                    prescale_p_d = wr_data_i[PRESCALE_WIDTH+7:8];
                end
                default: ;
            endcase
        end
    end

    // Active counters. Reload reads the pending registers' current (pre-write)
    // values, so a write in the reload cycle only shows up at the next reload.
    always_comb begin
        on_cnt_d      = on_cnt_q;
        per_cnt_d     = per_cnt_q;
        pre_cnt_d     = pre_cnt_q;
        period_done_d = 1'b0;
        if (reload_times_i) begin
            per_cnt_d = t_period_p_q;
            on_cnt_d  = on_load;
            pre_cnt_d = prescale_p_q;
        end else begin
            pre_cnt_d = tick ? prescale_p_q : (pre_cnt_q - PRESCALE_WIDTH'(1));
            if (dec_t_on_i && tick && (on_cnt_q != '0)) begin
                on_cnt_d = on_cnt_q - COUNT_WIDTH'(1);
            end
            if (dec_t_period_i && tick && (per_cnt_q != '0)) begin
                per_cnt_d     = per_cnt_q - COUNT_WIDTH'(1);
                // Only a real 1 -> 0 step ends a period; loading zero does not.
                period_done_d = (per_cnt_q == COUNT_WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t_period_p_q  <= '0;
            t_on_p_q      <= '0;
            enable_p_q    <= 1'b0;
            prescale_p_q  <= '0;
            on_cnt_q      <= '0;
            per_cnt_q     <= '0;
            pre_cnt_q     <= '0;
            period_done_q <= 1'b0;
        end else begin
            t_period_p_q  <= t_period_p_d;
            t_on_p_q      <= t_on_p_d;
            enable_p_q    <= enable_p_d;
            prescale_p_q  <= prescale_p_d;
            on_cnt_q      <= on_cnt_d;
            per_cnt_q     <= per_cnt_d;
            pre_cnt_q     <= pre_cnt_d;
            period_done_q <= period_done_d;
        end
    end

    assign t_on_zero_o     = (on_cnt_q == '0);
    assign t_period_zero_o = (per_cnt_q == '0);
    assign pwm_enable_o    = enable_p_q;
    assign period_done_o   = period_done_q;

endmodule

// File: tb/tb_pwm_timer.sv
module tb_pwm_timer;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic        dec_on;
    logic        dec_per;
    logic        reload;
    logic        t_on_zero;
    logic        t_period_zero;
    logic        pwm_enable;
    logic        period_done;

    int total = 0;
    int bad   = 0;

    pwm_timer #(
        .PWM_UNIT      (0),
        .COUNT_WIDTH   (32),
        .PRESCALE_WIDTH(8)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .wr_en_i        (wr_en),
        .wr_addr_i      (wr_addr),
        .wr_data_i      (wr_data),
        .dec_t_on_i     (dec_on),
        .dec_t_period_i (dec_per),
        .reload_times_i (reload),
        .t_on_zero_o    (t_on_zero),
        .t_period_zero_o(t_period_zero),
        .pwm_enable_o   (pwm_enable),
        .period_done_o  (period_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One table record: programming, strobe pattern and the expected number
    // of cycles after the reload edge at which each zero flag rises (-1 = never).
    typedef struct {
        logic [31:0] per;
        logic [31:0] on;
        logic [31:0] ctrl;
        bit          don;
        bit          dper;
        int          e_on;
        int          e_per;
        int          n;
        string       name;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic write(input logic [1:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    // Called right after the reload edge (k = 0); dec strobes already set.
    task automatic observe(input int e_on, input int e_per, input int n, input string name);
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s t_on_zero k=%0d", name, k), 64'(t_on_zero),
                64'((e_on >= 0) && (k >= e_on)));
            chk($sformatf("%s t_period_zero k=%0d", name, k), 64'(t_period_zero),
                64'((e_per >= 0) && (k >= e_per)));
            chk($sformatf("%s period_done k=%0d", name, k), 64'(period_done),
                64'((e_per > 0) && (k == e_per)));
            if (k < n - 1) step();
        end
    endtask

    task automatic run_trial(input logic [31:0] per, input logic [31:0] on,
                             input logic [31:0] ctrl, input bit don, input bit dper,
                             input int e_on, input int e_per, input int n,
                             input string name);
        write(2'd0, per);
        write(2'd1, on);
        write(2'd2, ctrl);
        chk({name, " pwm_enable"}, 64'(pwm_enable), 64'(ctrl[0]));
        dec_on  = don;
        dec_per = dper;
        reload  = 1'b1;
        step();
        reload  = 1'b0;
        observe(e_on, e_per, n, name);
        dec_on  = 1'b0;
        dec_per = 1'b0;
        $display("trial %s per=%0d on=%0d ctrl=%0h don=%0d dper=%0d e_on=%0d e_per=%0d bad=%0d",
                 name, per, on, ctrl, don, dper, e_on, e_per, bad);
    endtask

    initial begin
        int unsigned per_r, on_r, ps_r, on_eff;
        bit don_r, dper_r;
        logic [31:0] ctrl_r;
        int e_on_r, e_per_r;

        vecs[0] = '{32'd10, 32'd3,  32'h0000_0001, 1'b1, 1'b1, 3,  10, 14, "basic"};
        vecs[1] = '{32'd4,  32'd2,  32'h0000_0401, 1'b1, 1'b1, 10, 20, 24, "prescale4"};
        vecs[2] = '{32'd5,  32'd20, 32'h0000_0001, 1'b1, 1'b1, 5,  5,  8,  "clamp"};
        vecs[3] = '{32'd0,  32'd5,  32'h0000_0001, 1'b1, 1'b1, 0,  0,  6,  "per_zero"};
        vecs[4] = '{32'd6,  32'd0,  32'h0000_0201, 1'b1, 1'b1, 0,  18, 22, "on_zero"};
        vecs[5] = '{32'd7,  32'd4,  32'h0000_0000, 1'b0, 1'b1, -1, 7,  10, "no_dec_on"};
        vecs[6] = '{32'd3,  32'd3,  32'h0000_0101, 1'b1, 1'b0, 6,  -1, 10, "no_dec_per"};
        vecs[7] = '{32'd2,  32'd1,  32'hF000_03FF, 1'b1, 1'b1, 4,  8,  12, "ctrl_slice"};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 2'd0;
        wr_data = 32'd0;
        dec_on  = 1'b0;
        dec_per = 1'b0;
        reload  = 1'b0;

        // Reset state
        step();
        step();
        chk("reset t_on_zero", 64'(t_on_zero), 64'd1);
        chk("reset t_period_zero", 64'(t_period_zero), 64'd1);
        chk("reset pwm_enable", 64'(pwm_enable), 64'd0);
        chk("reset period_done", 64'(period_done), 64'd0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            run_trial(vecs[i].per, vecs[i].on, vecs[i].ctrl, vecs[i].don, vecs[i].dper,
                      vecs[i].e_on, vecs[i].e_per, vecs[i].n, vecs[i].name);
        end

        // Write in the reload cycle: active values come from the old pending T_on
        run_trial(32'd10, 32'd3, 32'h1, 1'b1, 1'b1, 3, 10, 14, "pre_same_cycle");
        wr_en   = 1'b1;
        wr_addr = 2'd1;
        wr_data = 32'd7;
        reload  = 1'b1;
        dec_on  = 1'b1;
        dec_per = 1'b1;
        step();
        wr_en   = 1'b0;
        reload  = 1'b0;
        observe(3, 10, 14, "same_cycle_old");
        reload = 1'b1;
        step();
        reload = 1'b0;
        observe(7, 10, 14, "same_cycle_new");
        dec_on  = 1'b0;
        dec_per = 1'b0;
        $display("trial same_cycle_write done bad=%0d", bad);

        // Address 3 changes nothing
        run_trial(32'd5, 32'd20, 32'h1, 1'b1, 1'b1, 5, 5, 8, "pre_addr3");
        write(2'd3, 32'h0000_0000);
        chk("addr3 pwm_enable", 64'(pwm_enable), 64'd1);
        dec_on  = 1'b1;
        dec_per = 1'b1;
        reload  = 1'b1;
        step();
        reload  = 1'b0;
        observe(5, 5, 8, "addr3");
        dec_on  = 1'b0;
        dec_per = 1'b0;
        $display("trial addr3 done bad=%0d", bad);

        // Randomised trials against the arithmetic timing model
        for (int t = 0; t < 20; t++) begin
            per_r  = $urandom_range(0, 12);
            on_r   = $urandom_range(0, 15);
            ps_r   = $urandom_range(0, 3);
            don_r  = 1'($urandom_range(0, 1));
            dper_r = 1'($urandom_range(0, 1));
            ctrl_r = ($urandom & 32'hFFFF_0000) | (ps_r << 8)
                   | (32'($urandom_range(0, 127)) << 1) | 32'($urandom_range(0, 1));
            on_eff = (on_r < per_r) ? on_r : per_r;
            if (on_eff == 0)      e_on_r = 0;
            else if (don_r)       e_on_r = int'(on_eff * (ps_r + 1));
            else                  e_on_r = -1;
            if (per_r == 0)       e_per_r = 0;
            else if (dper_r)      e_per_r = int'(per_r * (ps_r + 1));
            else                  e_per_r = -1;
            run_trial(per_r, on_r, ctrl_r, don_r, dper_r, e_on_r, e_per_r, 52,
                      $sformatf("rand%0d", t));
        end

        // Reset in the middle of a period
        write(2'd0, 32'd10);
        write(2'd1, 32'd8);
        write(2'd2, 32'h1);
        dec_on  = 1'b1;
        dec_per = 1'b1;
        reload  = 1'b1;
        step();
        reload  = 1'b0;
        step();
        step();
        step();
        step();
        chk("midreset pre t_period_zero", 64'(t_period_zero), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("midreset t_on_zero", 64'(t_on_zero), 64'd1);
        chk("midreset t_period_zero", 64'(t_period_zero), 64'd1);
        chk("midreset pwm_enable", 64'(pwm_enable), 64'd0);
        chk("midreset period_done", 64'(period_done), 64'd0);
        step();
        chk("midreset held period_done", 64'(period_done), 64'd0);
        chk("midreset held t_period_zero", 64'(t_period_zero), 64'd1);
        rst_n = 1'b1;
        dec_on  = 1'b0;
        dec_per = 1'b0;
        write(2'd2, 32'h1);
        chk("post_reset first write enable", 64'(pwm_enable), 64'd1);
        run_trial(32'd2, 32'd1, 32'h1, 1'b1, 1'b1, 1, 2, 5, "post_reset");
        $display("trial midreset done bad=%0d", bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_timer.md
PWM_TIMER -- requirements
Module: pwm_timer

Interface
REQ-001 Parameter PWM_UNIT, default 0: PWM channel index; identification only, no functional effect.
REQ-002 Parameter COUNT_WIDTH, default 32: width of the on-time and period counters.
REQ-003 Parameter PRESCALE_WIDTH, default 8: width of the prescale value and prescale counter.
REQ-004 Ports are listed below as name, direction, width, meaning.
REQ-005 clk  in  1  system clock; single clock domain.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 wr_en  in  1  register write strobe; sampled on the clk rising edge.
REQ-008 wr_addr  in  2  write address: 0 = T_period, 1 = T_on, 2 = control, 3 = ignored.
REQ-009 wr_data  in  COUNT_WIDTH  write data.
REQ-010 dec_T_on, dec_T_period, reload_times  in  1 each  command strobes from the downstream PWM state machine.
REQ-011 T_on_zero, T_period_zero  out  1 each  active counter equals zero.
REQ-012 pwm_enable  out  1  control register bit 0.
REQ-013 period_done  out  1  one-cycle pulse when the period counter decrements from 1 to 0.

Function
REQ-014 The block SHALL hold pending registers: T_period_p, T_on_p, enable_p (control bit 0) and prescale_p (control bits PRESCALE_WIDTH+7:8).
REQ-015 A write with wr_en=1 SHALL update the addressed pending register at the clk edge; wr_addr=3 SHALL change nothing.
REQ-016 pwm_enable SHALL equal enable_p directly, with no shadowing.
REQ-017 Active registers on_cnt, per_cnt and pre_cnt SHALL load only on a cycle with reload_times=1: per_cnt<=T_period_p; on_cnt<=min(T_on_p, T_period_p); pre_cnt<=prescale_p.
REQ-018 A write and reload_times in the same cycle SHALL load the active registers from the pending values held before that write; the write lands in the pending register and takes effect at the next reload.
REQ-019 tick SHALL be internal and equal (pre_cnt==0).
REQ-020 On a non-reload cycle, if tick=1 then pre_cnt<=prescale_p, else pre_cnt<=pre_cnt-1.
REQ-021 On a non-reload cycle with dec_T_on=1, tick=1 and on_cnt!=0, on_cnt SHALL decrement by 1.
REQ-022 On a non-reload cycle with dec_T_period=1, tick=1 and per_cnt!=0, per_cnt SHALL decrement by 1.
REQ-023 Counters SHALL saturate at 0 and never wrap to all-ones.
REQ-024 reload_times SHALL take priority over any dec_* strobe asserted in the same cycle.
REQ-025 T_on_zero SHALL be the combinational (on_cnt==0); T_period_zero SHALL be the combinational (per_cnt==0).
REQ-026 period_done SHALL be registered and pulse high for exactly 1 cycle, in the cycle after per_cnt goes 1->0 by decrement.
REQ-027 A reload that loads zero SHALL NOT assert period_done.
REQ-028 With prescale_p=0, tick SHALL be 1 every cycle; with prescale_p=N, each counter SHALL decrement at most once per N+1 cycles.
REQ-029 Effective on-time SHALL be on_cnt*(prescale+1) cycles; effective period SHALL be per_cnt*(prescale+1) cycles.
REQ-030 T_on_p > T_period_p SHALL yield 100% duty; T_on_p=0 SHALL make T_on_zero assert in the first cycle after reload.

Reset
REQ-031 reset=0 SHALL asynchronously clear all pending and active registers to 0 and period_done to 0.
REQ-032 During reset, T_on_zero=1, T_period_zero=1 and pwm_enable=0.
REQ-033 Reset asserted mid-period SHALL abort counting immediately; no period_done SHALL be emitted.
REQ-034 After reset release, the first edge SHALL behave normally.

Verification
REQ-035 Write T_period=10, T_on=3, control=0x1, then pulse reload_times -> pwm_enable=1 after the control write; on_cnt=3 and per_cnt=10 after reload; with dec_T_on=dec_T_period=1, T_on_zero rises 3 cycles later and T_period_zero rises 10 cycles later; period_done pulses once.
REQ-036 Prescale 4 (control=0x0401), T_on=2, T_period=4, dec strobes held -> T_on_zero after 10 cycles; T_period_zero after 20 cycles.
REQ-037 Write T_on=7 in the same cycle as reload_times, with T_on_p previously 3 -> on_cnt=3; the next reload gives on_cnt=7.
REQ-038 T_on=20, T_period=5, reload -> on_cnt=5 (clamped).
REQ-039 per_cnt=0 with dec_T_period held for 5 cycles -> per_cnt stays 0; period_done never pulses.
REQ-040 Assert reset with per_cnt=6 -> all counters 0 immediately; T_on_zero=T_period_zero=1; pwm_enable=0; period_done=0.
